afifo_wr_arbiter: RTL

Round-robin arbiter that shares the single async-FIFO write port among NUM_REQ requesters in the write-clock domain. A granted requester holds the port for one burst, ending on its last beat or at MAX_BURST beats, whichever comes first. The block drives winc/wdata toward the FIFO and never asserts winc while wfull is high. It also keeps a saturating count of full-stall cycles for the verification environment.

---
 rtl/afifo_wr_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/afifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ
// requesters in the write-clock domain.
//
// Ports:
//   wclk, wrst_n   write clock, async active-low reset
//   req_valid      per-requester beat valid
//   req_data       per-requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last       per-requester last-beat-of-burst flag
//   req_ready      one-hot per-requester beat accept
//   wfull          FIFO full flag
//   winc, wdata    FIFO write enable and data
//   grant_id       index of the current grant holder
//   grant_vld      a grant is active
//   stall_cnt      saturating count of cycles lost to wfull
module afifo_wr_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int MAX_BURST   = 8,
   parameter int STALL_CNT_W = 16,
   localparam int IW         = $clog2(NUM_REQ)
) (
   input  logic                          wclk,
   input  logic                          wrst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          wfull,
   output logic                          winc,
   output logic [DATA_WIDTH-1:0]         wdata,
   output logic [IW-1:0]                 grant_id,
   output logic                          grant_vld,
   output logic [STALL_CNT_W-1:0]        stall_cnt
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                state;
   logic [IW-1:0]         rr_ptr;
   logic [IW-1:0]         winner;
   logic [IW-1:0]         next_ptr;
   logic                  found;
   logic [7:0]            beat_cnt;
   logic                  cur_valid;
   logic                  cur_last;
   logic [DATA_WIDTH-1:0] cur_data;
   logic                  in_grant;
   logic                  last_beat;
   int                    idx;

   // Mux the grant holder's request signals.
   always_comb begin
      cur_valid = 1'b0;
      cur_last  = 1'b0;
      cur_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == IW'(i)) begin
            cur_valid = req_valid[i];
            cur_last  = req_last[i];
            cur_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // First valid requester searching upward from rr_ptr, with wrap.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ)
            idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = IW'(idx);
         end
      end
   end

   assign in_grant  = (state == GRANT);
   assign winc      = in_grant & cur_valid & ~wfull;
   assign wdata     = winc ? cur_data : '0;
   assign last_beat = cur_last | (beat_cnt == 8'(MAX_BURST - 1));
   assign next_ptr  = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

   always_comb begin
      req_ready = '0;
      if (in_grant)
         req_ready[grant_id] = ~wfull;
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state     <= IDLE;
         grant_vld <= 1'b0;
         grant_id  <= '0;
         rr_ptr    <= '0;
         beat_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  state     <= GRANT;
                  grant_id  <= winner;
                  grant_vld <= 1'b1;
                  beat_cnt  <= '0;
               end
            end
            GRANT: begin
               if (winc) begin
                  if (last_beat) begin
                     state     <= IDLE;
                     grant_vld <= 1'b0;
                     rr_ptr    <= next_ptr;
                     beat_cnt  <= '0;
                  end else begin
                     beat_cnt  <= beat_cnt + 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
         // A stall only counts when the holder actually had a beat ready.
         if (in_grant && cur_valid && wfull && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
